alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
Shares one combinational rv32i ALU between NUM_REQ requesters, e.g. the core datapath, an address-generation helper and a debug/test port. Uses round-robin arbitration with per-requester valid/ready handshakes. The block instantiates the ALU internally and registers the result into a single-entry response slot. The slot carries the winning requester ID and drains through a valid/ready output handshake.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (combinational)
req_op1  in  32*NUM_REQ  flattened operand 1; requester i at [32*i+31:32*i]
req_op2  in  32*NUM_REQ  flattened operand 2, same packing
req_instr  in  4*NUM_REQ  flattened 4-bit ALU instruction code, requester i at [4*i+3:4*i]
rsp_valid  out  1  response slot holds a result
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  registered ALU result
rsp_id  out  ID_W  index of requester that produced rsp_data
rsp_err  out  1  unsupported instruction code flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, RR pointer last_grant=NUM_REQ-1. Requester 0 therefore has first priority after reset.
- Interface: clock port is clk; reset port is rst_n, asynchronous, active-low.
- ALU instruction codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SRA; 0100 SLL.
  - 0101 SLT (signed); 0110 SUB; 0111 SLTU; 1000 SRL; 1001 XOR.
  - Any other code yields result 0.
  - Shift amount is op2[4:0].
- Slot open: accept = !rsp_valid || rsp_ready. A full slot being drained in the same cycle counts as open, giving full throughput of one op per cycle.
- Grant: when accept=1 and any req_valid=1, pick the first valid requester searching upward from last_grant+1, modulo NUM_REQ. Exactly one req_ready bit is high: the granted index. req_ready is all-zero when accept=0 or no request is valid.
- Handshake on requester i (req_valid[i] && req_ready[i]):
  - ALU computes from requester i's operands in that cycle.
  - At the next edge: rsp_data<=result, rsp_id<=i, rsp_valid<=1, last_grant<=i.
  - Latency is one cycle from request handshake to rsp_valid.
- last_grant updates only on a handshake; idle cycles do not rotate priority.
- Response drain: rsp_valid && rsp_ready with no new handshake -> rsp_valid<=0 next edge. rsp_data and rsp_id hold their last values.
- Simultaneous drain + new handshake: slot is overwritten with the new result and rsp_valid stays 1. No bubble, no lost response.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all req_ready=0. rsp_data, rsp_id and rsp_err hold stable.
- Requester rule: once req_valid is asserted, the requester holds operands and instr stable until its handshake. The block does not sample them early.
- Fairness: a continuously valid requester is granted within NUM_REQ slot-open cycles.
- Reset mid-operation: a pending response is discarded, rsp_valid drops immediately (asynchronously), and the pointer returns to NUM_REQ-1.
- Requester indices >= NUM_REQ do not exist; no X propagation from unused rsp_id codes.

Optional Feature:
Macro ALU_SHARE_ARB_ILLEGAL_CHK_EN.
- Defined: rsp_err is registered alongside rsp_data. It is set to 1 when the granted instr code is outside the ten legal codes, otherwise 0. rsp_data is 0 in that case.
- Not defined: rsp_err is tied to 0 and no checking logic is built. Illegal codes still return 0.

Test Plan:
- Reset then a single request: req 1 sends ADD, op1=0x00000005, op2=0x00000003 -> req_ready[1]=1 that cycle; next cycle rsp_valid=1, rsp_data=0x00000008, rsp_id=1.
- All three requesters hold valid continuously with rsp_ready=1 -> grants 0,1,2,0,1,2 on consecutive cycles; one response per cycle with matching rsp_id.
- Backpressure: rsp_valid=1, rsp_ready=0 for 4 cycles while req 2 is valid -> req_ready=0 throughout and rsp_data held. Release rsp_ready -> req 2 granted the same cycle, response on the next cycle.
- Arithmetic spot checks:
  - SRA op1=0x80000000, op2=0x00000024 -> 0xF8000000 (shift 4).
  - SLT op1=0xFFFFFFFF, op2=1 -> 1.
  - SLTU with the same operands -> 0.
  - SUB op1=3, op2=5 -> 0xFFFFFFFE.
- rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately. After release, requesters 0 and 2 both valid -> requester 0 granted first.
- With ALU_SHARE_ARB_ILLEGAL_CHK_EN: instr=4'b1111 -> rsp_data=0, rsp_err=1. The following legal op -> rsp_err=0. Without the macro, rsp_err stays 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one rv32i ALU among NUM_REQ requesters, result held in a one-entry slot.
// Latency: 1 cycle from request handshake to rsp_valid; sustains one op per cycle while rsp_ready is high.
// Backpressure: a full slot with rsp_ready low forces all req_ready low. Optional: ALU_SHARE_ARB_ILLEGAL_CHK_EN.
module alu_share_arb #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_op1,
  input  logic [32*NUM_REQ-1:0]  req_op2,
  input  logic [4*NUM_REQ-1:0]   req_instr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err
);

  logic            r_valid;
  logic [31:0]     r_data;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_last_grant;

  logic            w_accept;
  logic            w_found;
  logic            w_hs;
  logic [ID_W-1:0] w_sel;
  logic [31:0]     w_op1;
  logic [31:0]     w_op2;
  logic [3:0]      w_instr;
  logic [31:0]     w_result;
  logic [4:0]      w_shamt;

  // A slot being drained this cycle is as good as empty.
  assign w_accept = !r_valid || rsp_ready;
  assign w_hs     = w_accept && w_found;

  // Round-robin search upward from the last winner; indices wrap at NUM_REQ, not at 2**ID_W.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_sel   = ID_W'(idx);
      end
    end
  end

  // One-hot ready on the winner only when the slot can take the result; operand mux for the winner.
  always_comb begin
    req_ready = '0;
    w_op1     = '0;
    w_op2     = '0;
    w_instr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == ID_W'(i)) begin
        req_ready[i] = w_hs;
        w_op1        = req_op1[32*i +: 32];
        w_op2        = req_op2[32*i +: 32];
        w_instr      = req_instr[4*i +: 4];
      end
    end
  end

  assign w_shamt = w_op2[4:0];

  // Shared combinational ALU; unlisted codes produce zero.
  always_comb begin
    w_result = '0;
    case (w_instr)
      4'b0000: w_result = w_op1 & w_op2;
      4'b0001: w_result = w_op1 | w_op2;
      4'b0010: w_result = w_op1 + w_op2;
      4'b0011: w_result = $unsigned($signed(w_op1) >>> w_shamt);
      4'b0100: w_result = w_op1 << w_shamt;
      4'b0101: w_result = {31'b0, ($signed(w_op1) < $signed(w_op2))};
      4'b0110: w_result = w_op1 - w_op2;
      4'b0111: w_result = {31'b0, (w_op1 < w_op2)};
      4'b1000: w_result = w_op1 >> w_shamt;
      4'b1001: w_result = w_op1 ^ w_op2;
      default: w_result = '0;
    endcase
  end

  // Response slot and priority pointer; pointer moves only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else if (w_hs) begin
      r_valid      <= 1'b1;
      r_data       <= w_result;
      r_id         <= w_sel;
      r_last_grant <= w_sel;
    end else if (rsp_ready) begin
      r_valid      <= 1'b0;
    end
  end

`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
  logic r_err;

  // Error flag travels with the result it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_hs) begin
      r_err <= (w_instr > 4'd9);
    end
  end

  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = r_valid;
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  localparam int N = 3;
`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_op1 = '0;
  logic [32*N-1:0] req_op2 = '0;
  logic [4*N-1:0]  req_instr = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_err;

  always #5 clk = ~clk;

  alu_share_arb #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_instr(req_instr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] d;
    int          id;
    logic        e;
  } rsp_t;

  int   tests = 0;
  int   fails = 0;
  rsp_t q[$];
  bit   run = 1'b0;
  bit   m_valid = 1'b0;
  int   m_last = N - 1;
  bit   hs[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU: {illegal, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int          s;
    s = int'(b[4:0]);
    r = 32'h0;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = (a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'h0);
      4'd4: r = a << s;
      4'd5: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6: r = a - b;
      4'd7: r = (a < b) ? 32'd1 : 32'd0;
      4'd8: r = a >> s;
      4'd9: r = a ^ b;
      default: r = 32'h0;
    endcase
    return {(c > 4'd9), r};
  endfunction

  // Model: decide the grant from the arbitration rule, check req_ready, queue the expected response.
  always @(negedge clk) begin
    bit           acc;
    int           g;
    int           i;
    logic [N-1:0] exp_rdy;
    logic [32:0]  res;
    rsp_t         e;
    if (run && rst_n) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      acc = !m_valid || rsp_ready;
      g = -1;
      if (acc) begin
        for (int k = 1; k <= N; k++) begin
          i = (m_last + k) % N;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int j = 0; j < N; j++) hs[j] = 1'b0;
      if (g >= 0) begin
        res  = ref_alu(req_instr[4*g +: 4], req_op1[32*g +: 32], req_op2[32*g +: 32]);
        e.d  = res[31:0];
        e.id = g;
        e.e  = CHK_EN & res[32];
        q.push_back(e);
        m_last  = g;
        m_valid = 1'b1;
        hs[g]   = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: whatever the slot presents must be the oldest expected response; pop on drain.
  always @(negedge clk) begin
    if (run && rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        chk("rsp_data", 64'(rsp_data), 64'(q[0].d));
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_err", 64'(rsp_err), 64'(q[0].e));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = 1'b1;
    req_instr[4*i +: 4] = c;
    req_op1[32*i +: 32] = a;
    req_op2[32*i +: 32] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) req_valid[i] = 1'b0;
  endtask

  // Single request on an open slot with nothing else pending: granted at once, result visible after one edge.
  task automatic issue(input string name, input int i, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    set_req(i, c, a, b);
    @(negedge clk);
    chk({name, "_rdy"}, 64'(req_ready), 64'(1 << i));
    step();
    chk({name, "_vld"}, 64'(rsp_valid), 64'(1));
    chk({name, "_data"}, 64'(rsp_data), 64'(exp));
    chk({name, "_id"}, 64'(rsp_id), 64'(i));
  endtask

  initial begin
    for (int j = 0; j < N; j++) hs[j] = 1'b0;
    #1 rst_n = 1'b0;
    #20;
    chk("reset_vld", 64'(rsp_valid), 64'(0));
    chk("reset_data", 64'(rsp_data), 64'(0));
    chk("reset_id", 64'(rsp_id), 64'(0));
    chk("reset_err", 64'(rsp_err), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;

    // Single ADD from requester 1
    issue("add1", 1, 4'b0010, 32'h5, 32'h3, 32'h8);

    // Round robin with everyone valid; pointer last moved to 1, so order starts at 2
    for (int i = 0; i < N; i++) set_req(i, 4'($urandom_range(0, 9)), $urandom, $urandom);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(1 << ((k + 2) % 3)));
      step();
      if (k < 3) begin
        for (int i = 0; i < N; i++)
          if (!req_valid[i]) set_req(i, 4'($urandom_range(0, 9)), $urandom, $urandom);
      end
    end

    // Backpressure: slot full, consumer stalled, requester 2 waiting
    rsp_ready = 1'b0;
    set_req(2, 4'b1001, 32'hA5A5_0F0F, 32'hFFFF_0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rdy", 64'(req_ready), 64'(0));
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(req_ready), 64'(3'b100));
    step();
    chk("bp_release_data", 64'(rsp_data), 64'(32'h5A5A_0F0F));
    chk("bp_release_id", 64'(rsp_id), 64'(2));

    // Arithmetic spot checks
    issue("sra", 0, 4'b0011, 32'h8000_0000, 32'h24, 32'hF800_0000);
    issue("slt", 0, 4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h1);
    issue("sltu", 0, 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0);
    issue("sub", 0, 4'b0110, 32'h3, 32'h5, 32'hFFFF_FFFE);
    issue("illegal", 1, 4'b1111, 32'h1234_5678, 32'h1, 32'h0);
    chk("illegal_err", 64'(rsp_err), 64'(CHK_EN));
    issue("legal_after", 1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    chk("legal_err", 64'(rsp_err), 64'(0));

    // Randomized traffic; requesters hold their operands until handshake
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || hs[i]) begin
          if ($urandom_range(0, 3) != 0) set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
          else req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) step();
    chk("drain_pending", 64'(req_valid), 64'(0));
    chk("drain_queue", 64'(q.size()), 64'(0));

    // Asynchronous reset with a response pending
    rsp_ready = 1'b0;
    set_req(1, 4'b0010, 32'h10, 32'h20);
    @(negedge clk);
    step();
    #2;
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(rsp_valid), 64'(0));
    chk("arst_data", 64'(rsp_data), 64'(0));
    q.delete();
    m_valid = 1'b0;
    m_last = N - 1;
    for (int j = 0; j < N; j++) hs[j] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 4'b0001, 32'h0F00, 32'h00F0);
    set_req(2, 4'b0100, 32'h1, 32'h4);
    run = 1'b1;
    @(negedge clk);
    chk("post_rst_first", 64'(req_ready), 64'(3'b001));
    step();
    chk("post_rst_data0", 64'(rsp_data), 64'(32'h0FF0));
    @(negedge clk);
    chk("post_rst_second", 64'(req_ready), 64'(3'b100));
    step();
    chk("post_rst_data2", 64'(rsp_data), 64'(32'h10));
    for (int c = 0; c < 3; c++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
